// File: rtl/issue_queue.sv
// Unified reservation station between rename/dispatch and execute.
// Holds renamed micro-ops and tracks operand readiness from CDB wakeups.
// Each cycle the oldest fully-ready entry (ROB age relative to rob_head) moves
// into a registered issue slot that execute drains through a valid/ready pair.
module issue_queue #(
  parameter int unsigned NUM_RS_ENTRIES = 8,
  parameter int unsigned PHY_WIDTH      = 6,
  parameter int unsigned ROB_WIDTH      = 5,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned OP_WIDTH       = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush_i,
  input  logic [ROB_WIDTH-1:0]                 rob_head_i,
  // Dispatch side
  input  logic                                 dispatch_valid_i,
  output logic                                 dispatch_ready_o,
  input  logic [ROB_WIDTH-1:0]                 dispatch_rob_id_i,
  input  logic [OP_WIDTH-1:0]                  dispatch_op_i,
  input  logic [PHY_WIDTH-1:0]                 dispatch_prd_i,
  input  logic [PHY_WIDTH-1:0]                 dispatch_prs1_i,
  input  logic [PHY_WIDTH-1:0]                 dispatch_prs2_i,
  input  logic                                 dispatch_rs1_ready_i,
  input  logic                                 dispatch_rs2_ready_i,
  input  logic [DATA_WIDTH-1:0]                dispatch_imm_i,
  // Wakeup broadcast
  input  logic                                 cdb_valid_i,
  input  logic [PHY_WIDTH-1:0]                 cdb_prd_i,
  // Issue slot
  output logic                                 issue_valid_o,
  input  logic                                 issue_ready_i,
  output logic [ROB_WIDTH-1:0]                 issue_rob_id_o,
  output logic [OP_WIDTH-1:0]                  issue_op_o,
  output logic [PHY_WIDTH-1:0]                 issue_prd_o,
  output logic [PHY_WIDTH-1:0]                 issue_prs1_o,
  output logic [PHY_WIDTH-1:0]                 issue_prs2_o,
  output logic [DATA_WIDTH-1:0]                issue_imm_o,
  output logic [$clog2(NUM_RS_ENTRIES):0]      occupancy_o
);

  localparam int unsigned IdxW = (NUM_RS_ENTRIES > 1) ? $clog2(NUM_RS_ENTRIES) : 1;
  localparam int unsigned CntW = $clog2(NUM_RS_ENTRIES) + 1;

  // Entry storage
  logic [NUM_RS_ENTRIES-1:0] valid_q, valid_d;
  logic [NUM_RS_ENTRIES-1:0] rdy1_q, rdy1_d;
  logic [NUM_RS_ENTRIES-1:0] rdy2_q, rdy2_d;
  logic [ROB_WIDTH-1:0]      rob_q  [NUM_RS_ENTRIES];
  logic [ROB_WIDTH-1:0]      rob_d  [NUM_RS_ENTRIES];
  logic [OP_WIDTH-1:0]       op_q   [NUM_RS_ENTRIES];
  logic [OP_WIDTH-1:0]       op_d   [NUM_RS_ENTRIES];
  logic [PHY_WIDTH-1:0]      prd_q  [NUM_RS_ENTRIES];
  logic [PHY_WIDTH-1:0]      prd_d  [NUM_RS_ENTRIES];
  logic [PHY_WIDTH-1:0]      prs1_q [NUM_RS_ENTRIES];
  logic [PHY_WIDTH-1:0]      prs1_d [NUM_RS_ENTRIES];
  logic [PHY_WIDTH-1:0]      prs2_q [NUM_RS_ENTRIES];
  logic [PHY_WIDTH-1:0]      prs2_d [NUM_RS_ENTRIES];
  logic [DATA_WIDTH-1:0]     imm_q  [NUM_RS_ENTRIES];
  logic [DATA_WIDTH-1:0]     imm_d  [NUM_RS_ENTRIES];

  // Issue slot and count
  logic                  iss_valid_q, iss_valid_d;
  logic [ROB_WIDTH-1:0]  iss_rob_q, iss_rob_d;
  logic [OP_WIDTH-1:0]   iss_op_q, iss_op_d;
  logic [PHY_WIDTH-1:0]  iss_prd_q, iss_prd_d;
  logic [PHY_WIDTH-1:0]  iss_prs1_q, iss_prs1_d;
  logic [PHY_WIDTH-1:0]  iss_prs2_q, iss_prs2_d;
  logic [DATA_WIDTH-1:0] iss_imm_q, iss_imm_d;
  logic [CntW-1:0]       occ_q, occ_d;

  logic            accept;
  logic            slot_free;
  logic            load;
  logic            free_found;
  logic [IdxW-1:0] free_idx;
  logic            sel_found;
  logic [IdxW-1:0] sel_idx;

  // Credit check uses the registered count only; a same-cycle issue is not credited.
  assign dispatch_ready_o = !rst && (occ_q < CntW'(NUM_RS_ENTRIES));
  assign accept           = dispatch_valid_i && dispatch_ready_o;
  assign slot_free        = !iss_valid_q || issue_ready_i;
  assign load             = slot_free && sel_found;

  // Lowest-index free entry, from registered valid bits.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
    end
  end

  // Oldest eligible entry by modular ROB age; strict compare keeps lower index on ties.
  always_comb begin
    logic [ROB_WIDTH-1:0] age;
    logic [ROB_WIDTH-1:0] best_age;
    sel_found = 1'b0;
    sel_idx   = '0;
    best_age  = '0;
    age       = '0;
    for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
      age = rob_q[i] - rob_head_i;
      if (valid_q[i] && rdy1_q[i] && rdy2_q[i] && (!sel_found || age < best_age)) begin
        sel_found = 1'b1;
        sel_idx   = IdxW'(i);
        best_age  = age;
      end
    end
  end

  // Next state: wakeup, issue-slot load/drain, dispatch write, occupancy.
  always_comb begin
    valid_d     = valid_q;
    rdy1_d      = rdy1_q;
    rdy2_d      = rdy2_q;
    rob_d       = rob_q;
    op_d        = op_q;
    prd_d       = prd_q;
    prs1_d      = prs1_q;
    prs2_d      = prs2_q;
    imm_d       = imm_q;
    iss_valid_d = iss_valid_q;
    iss_rob_d   = iss_rob_q;
    iss_op_d    = iss_op_q;
    iss_prd_d   = iss_prd_q;
    iss_prs1_d  = iss_prs1_q;
    iss_prs2_d  = iss_prs2_q;
    iss_imm_d   = iss_imm_q;

    if (cdb_valid_i) begin
      for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
        if (prs1_q[i] == cdb_prd_i) rdy1_d[i] = 1'b1;
        if (prs2_q[i] == cdb_prd_i) rdy2_d[i] = 1'b1;
      end
    end

    if (slot_free) begin
      iss_valid_d = sel_found;
      if (sel_found) begin
        iss_rob_d        = rob_q[sel_idx];
        iss_op_d         = op_q[sel_idx];
        iss_prd_d        = prd_q[sel_idx];
        iss_prs1_d       = prs1_q[sel_idx];
        iss_prs2_d       = prs2_q[sel_idx];
        iss_imm_d        = imm_q[sel_idx];
        valid_d[sel_idx] = 1'b0;
      end
    end

    // The free slot is never the one being issued: it comes from registered valid bits.
    if (accept && free_found) begin
      valid_d[free_idx] = 1'b1;
      rob_d[free_idx]   = dispatch_rob_id_i;
      op_d[free_idx]    = dispatch_op_i;
      prd_d[free_idx]   = dispatch_prd_i;
      prs1_d[free_idx]  = dispatch_prs1_i;
      prs2_d[free_idx]  = dispatch_prs2_i;
      imm_d[free_idx]   = dispatch_imm_i;
      rdy1_d[free_idx]  = dispatch_rs1_ready_i || (dispatch_prs1_i == '0) ||
                          (cdb_valid_i && (cdb_prd_i == dispatch_prs1_i));
      rdy2_d[free_idx]  = dispatch_rs2_ready_i || (dispatch_prs2_i == '0) ||
                          (cdb_valid_i && (cdb_prd_i == dispatch_prs2_i));
    end

    occ_d = occ_q + CntW'(accept) - CntW'(load);
  end

  // State registers; reset and flush both squash everything.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      valid_q     <= '0;
      rdy1_q      <= '0;
      rdy2_q      <= '0;
      for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
        rob_q[i]  <= '0;
        op_q[i]   <= '0;
        prd_q[i]  <= '0;
        prs1_q[i] <= '0;
        prs2_q[i] <= '0;
        imm_q[i]  <= '0;
      end
      iss_valid_q <= 1'b0;
      iss_rob_q   <= '0;
      iss_op_q    <= '0;
      iss_prd_q   <= '0;
      iss_prs1_q  <= '0;
      iss_prs2_q  <= '0;
      iss_imm_q   <= '0;
      occ_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      rdy1_q      <= rdy1_d;
      rdy2_q      <= rdy2_d;
      rob_q       <= rob_d;
      op_q        <= op_d;
      prd_q       <= prd_d;
      prs1_q      <= prs1_d;
      prs2_q      <= prs2_d;
      imm_q       <= imm_d;
      iss_valid_q <= iss_valid_d;
      iss_rob_q   <= iss_rob_d;
      iss_op_q    <= iss_op_d;
      iss_prd_q   <= iss_prd_d;
      iss_prs1_q  <= iss_prs1_d;
      iss_prs2_q  <= iss_prs2_d;
      iss_imm_q   <= iss_imm_d;
      occ_q       <= occ_d;
    end
  end

  assign issue_valid_o  = iss_valid_q;
  assign issue_rob_id_o = iss_rob_q;
  assign issue_op_o     = iss_op_q;
  assign issue_prd_o    = iss_prd_q;
  assign issue_prs1_o   = iss_prs1_q;
  assign issue_prs2_o   = iss_prs2_q;
  assign issue_imm_o    = iss_imm_q;
  assign occupancy_o    = occ_q;

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the reservation station.
module tb_issue_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [4:0]  rob_head;
  logic        dispatch_valid;
  logic        dispatch_ready;
  logic [4:0]  dispatch_rob_id;
  logic [7:0]  dispatch_op;
  logic [5:0]  dispatch_prd;
  logic [5:0]  dispatch_prs1;
  logic [5:0]  dispatch_prs2;
  logic        dispatch_rs1_ready;
  logic        dispatch_rs2_ready;
  logic [31:0] dispatch_imm;
  logic        cdb_valid;
  logic [5:0]  cdb_prd;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_rob_id;
  logic [7:0]  issue_op;
  logic [5:0]  issue_prd;
  logic [5:0]  issue_prs1;
  logic [5:0]  issue_prs2;
  logic [31:0] issue_imm;
  logic [3:0]  occupancy;

  issue_queue dut (
    .clk                  (clk),
    .rst                  (rst),
    .flush_i              (flush),
    .rob_head_i           (rob_head),
    .dispatch_valid_i     (dispatch_valid),
    .dispatch_ready_o     (dispatch_ready),
    .dispatch_rob_id_i    (dispatch_rob_id),
    .dispatch_op_i        (dispatch_op),
    .dispatch_prd_i       (dispatch_prd),
    .dispatch_prs1_i      (dispatch_prs1),
    .dispatch_prs2_i      (dispatch_prs2),
    .dispatch_rs1_ready_i (dispatch_rs1_ready),
    .dispatch_rs2_ready_i (dispatch_rs2_ready),
    .dispatch_imm_i       (dispatch_imm),
    .cdb_valid_i          (cdb_valid),
    .cdb_prd_i            (cdb_prd),
    .issue_valid_o        (issue_valid),
    .issue_ready_i        (issue_ready),
    .issue_rob_id_o       (issue_rob_id),
    .issue_op_o           (issue_op),
    .issue_prd_o          (issue_prd),
    .issue_prs1_o         (issue_prs1),
    .issue_prs2_o         (issue_prs2),
    .issue_imm_o          (issue_imm),
    .occupancy_o          (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rob;
    logic [7:0]  op;
    logic [5:0]  prd;
    logic [5:0]  prs1;
    logic [5:0]  prs2;
    logic        r1;
    logic        r2;
    logic [31:0] imm;
  } ent_t;

  // Reference model: waiting ops (order irrelevant) plus the issue slot.
  ent_t m_q[$];
  ent_t m_slot;
  bit   m_slot_v;
  bit   m_was_reset;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t zero_ent();
    ent_t e;
    e.rob = '0; e.op = '0; e.prd = '0; e.prs1 = '0; e.prs2 = '0;
    e.r1 = 1'b0; e.r2 = 1'b0; e.imm = '0;
    return e;
  endfunction

  function automatic bit rob_in_use(input logic [4:0] r);
    foreach (m_q[i]) if (m_q[i].rob == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle();
    dispatch_valid = 1'b0;
    cdb_valid      = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic disp(input logic [4:0] rob, input logic [7:0] op, input logic [5:0] p1,
                      input logic [5:0] p2, input logic r1, input logic r2,
                      input logic [31:0] imm);
    dispatch_valid     = 1'b1;
    dispatch_rob_id    = rob;
    dispatch_op        = op;
    dispatch_prd       = 6'(rob + 5'd1);
    dispatch_prs1      = p1;
    dispatch_prs2      = p2;
    dispatch_rs1_ready = r1;
    dispatch_rs2_ready = r2;
    dispatch_imm       = imm;
  endtask

  // One clock: predict next state from the rules, advance, compare.
  task automatic tick();
    ent_t nq[$];
    ent_t nslot;
    ent_t e;
    bit   nslot_v;
    bit   found;
    int   bi;
    logic [4:0] a, ba;
    #1;
    check_eq("dispatch_ready", 64'(dispatch_ready), 64'(!rst && (m_q.size() < 8)));
    nq = m_q;
    nslot = m_slot;
    nslot_v = m_slot_v;
    if (rst || flush) begin
      nq.delete();
      nslot = zero_ent();
      nslot_v = 1'b0;
    end else begin
      if (!m_slot_v || issue_ready) begin
        found = 1'b0; bi = 0; ba = '0;
        foreach (m_q[i]) begin
          a = 5'(m_q[i].rob - rob_head);
          if (m_q[i].r1 && m_q[i].r2 && (!found || a < ba)) begin
            found = 1'b1; bi = i; ba = a;
          end
        end
        nslot_v = found;
        if (found) begin
          nslot = m_q[bi];
          nq.delete(bi);
        end
      end
      if (cdb_valid) begin
        foreach (nq[i]) begin
          if (nq[i].prs1 == cdb_prd) nq[i].r1 = 1'b1;
          if (nq[i].prs2 == cdb_prd) nq[i].r2 = 1'b1;
        end
      end
      if (dispatch_valid && m_q.size() < 8) begin
        e.rob = dispatch_rob_id; e.op = dispatch_op; e.prd = dispatch_prd;
        e.prs1 = dispatch_prs1; e.prs2 = dispatch_prs2; e.imm = dispatch_imm;
        e.r1 = dispatch_rs1_ready || dispatch_prs1 == 0 || (cdb_valid && cdb_prd == dispatch_prs1);
        e.r2 = dispatch_rs2_ready || dispatch_prs2 == 0 || (cdb_valid && cdb_prd == dispatch_prs2);
        nq.push_back(e);
      end
    end
    m_was_reset = rst || flush;
    @(posedge clk);
    #1;
    m_q = nq;
    m_slot = nslot;
    m_slot_v = nslot_v;
    check_eq("issue_valid", 64'(issue_valid), 64'(m_slot_v));
    check_eq("occupancy", 64'(occupancy), 64'(m_q.size()));
    if (m_slot_v || m_was_reset) begin
      check_eq("issue_rob_id", 64'(issue_rob_id), 64'(m_slot.rob));
      check_eq("issue_op", 64'(issue_op), 64'(m_slot.op));
      check_eq("issue_prd", 64'(issue_prd), 64'(m_slot.prd));
      check_eq("issue_prs1", 64'(issue_prs1), 64'(m_slot.prs1));
      check_eq("issue_prs2", 64'(issue_prs2), 64'(m_slot.prs2));
      check_eq("issue_imm", 64'(issue_imm), 64'(m_slot.imm));
    end
  endtask

  initial begin
    logic [4:0] r;
    m_slot = zero_ent();
    m_slot_v = 1'b0;
    rst = 1'b1; flush = 1'b0; rob_head = '0; issue_ready = 1'b1;
    idle();
    disp(5'd0, 8'd0, 6'd0, 6'd0, 1'b0, 1'b0, 32'd0);
    dispatch_valid = 1'b0;
    tick(); tick();
    check_eq("rst_issue_valid", 64'(issue_valid), 64'(0));
    check_eq("rst_occupancy", 64'(occupancy), 64'(0));
    check_eq("rst_issue_imm", 64'(issue_imm), 64'(0));
    rst = 1'b0;

    // Ready at dispatch: visible after the following edge.
    disp(5'd3, 8'h11, 6'd5, 6'd7, 1'b1, 1'b1, 32'h10);
    tick();
    check_eq("t1_not_yet", 64'(issue_valid), 64'(0));
    idle(); tick();
    check_eq("t1_valid", 64'(issue_valid), 64'(1));
    check_eq("t1_rob", 64'(issue_rob_id), 64'(3));
    check_eq("t1_imm", 64'(issue_imm), 64'h10);
    tick();
    check_eq("t1_occ", 64'(occupancy), 64'(0));
    check_eq("t1_drained", 64'(issue_valid), 64'(0));

    // Wakeup latency, then wakeup in the dispatch cycle.
    disp(5'd4, 8'h22, 6'd9, 6'd0, 1'b0, 1'b0, 32'h20);
    tick(); idle(); tick(); tick();
    cdb_valid = 1'b1; cdb_prd = 6'd9; tick();
    check_eq("t2_wake_edge", 64'(issue_valid), 64'(0));
    idle(); tick();
    check_eq("t2_woken", 64'(issue_valid), 64'(1));
    check_eq("t2_rob", 64'(issue_rob_id), 64'(4));
    tick();
    disp(5'd5, 8'h33, 6'd9, 6'd0, 1'b0, 1'b0, 32'h30);
    cdb_valid = 1'b1; cdb_prd = 6'd9; tick();
    idle(); tick();
    check_eq("t2b_rob", 64'(issue_rob_id), 64'(5));
    check_eq("t2b_valid", 64'(issue_valid), 64'(1));
    tick();

    // Fill to capacity with unready ops.
    for (int i = 0; i < 8; i++) begin
      disp(5'(6 + i), 8'(i), 6'(20 + i), 6'd0, 1'b0, 1'b0, 32'(i));
      tick();
    end
    check_eq("t3_occ_full", 64'(occupancy), 64'(8));
    check_eq("t3_ready_low", 64'(dispatch_ready), 64'(0));
    disp(5'd14, 8'h44, 6'd1, 6'd0, 1'b1, 1'b1, 32'h44);
    tick();
    check_eq("t3_not_accepted", 64'(occupancy), 64'(8));
    idle(); cdb_valid = 1'b1; cdb_prd = 6'd20; issue_ready = 1'b0; tick();
    idle(); tick();
    check_eq("t3_issue_rob", 64'(issue_rob_id), 64'(6));
    check_eq("t3_occ_after", 64'(occupancy), 64'(7));
    check_eq("t3_ready_back", 64'(dispatch_ready), 64'(1));
    flush = 1'b1; tick();
    check_eq("t3_flush_valid", 64'(issue_valid), 64'(0));
    check_eq("t3_flush_occ", 64'(occupancy), 64'(0));
    check_eq("t3_flush_ready", 64'(dispatch_ready), 64'(1));

    // Reset concurrent with flush, with a loaded slot and 5 waiting entries.
    idle();
    for (int i = 0; i < 6; i++) begin
      disp(5'(i), 8'(i), 6'd0, 6'd0, 1'b1, 1'b1, 32'(i));
      tick();
    end
    idle(); tick();
    check_eq("t6_occ", 64'(occupancy), 64'(5));
    rst = 1'b1; flush = 1'b1; tick();
    check_eq("t6_valid", 64'(issue_valid), 64'(0));
    check_eq("t6_occ0", 64'(occupancy), 64'(0));
    rst = 1'b0; flush = 1'b0;
    #1;
    check_eq("t6_ready", 64'(dispatch_ready), 64'(1));

    // Wrap-around age ordering with a held slot.
    rob_head = 5'd30;
    disp(5'd29, 8'h29, 6'd0, 6'd0, 1'b1, 1'b1, 32'h29); tick();
    disp(5'd31, 8'h31, 6'd0, 6'd0, 1'b1, 1'b1, 32'h31); tick();
    disp(5'd1,  8'h01, 6'd0, 6'd0, 1'b1, 1'b1, 32'h01); tick();
    disp(5'd30, 8'h30, 6'd0, 6'd0, 1'b1, 1'b1, 32'h30); tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t5_hold_rob", 64'(issue_rob_id), 64'(29));
      check_eq("t5_hold_occ", 64'(occupancy), 64'(3));
    end
    issue_ready = 1'b1; tick();
    check_eq("t4_first", 64'(issue_rob_id), 64'(30));
    tick();
    check_eq("t4_second", 64'(issue_rob_id), 64'(31));
    tick();
    check_eq("t4_third", 64'(issue_rob_id), 64'(1));
    tick();
    check_eq("t4_empty", 64'(issue_valid), 64'(0));

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 79) == 0);
      rob_head = 5'($urandom);
      issue_ready = ($urandom_range(0, 9) < 7);
      cdb_valid = $urandom_range(0, 1) != 0;
      cdb_prd   = 6'($urandom_range(0, 15));
      do r = 5'($urandom); while (rob_in_use(r));
      disp(r, 8'($urandom), 6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)),
           ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3), $urandom);
      dispatch_valid = ($urandom_range(0, 9) < 6);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Unified reservation station between rename/dispatch and the execution stage of the out-of-order core.
- Holds up to NUM_RS_ENTRIES renamed micro-ops and tracks source-operand readiness from CDB wakeups.
- Each cycle it selects the oldest fully-ready entry, by ROB age relative to rob_head, into a registered issue slot.
- The execution stage consumes that slot through a valid/ready handshake.

Parameters:
- NUM_RS_ENTRIES, 8: number of queue entries.
- PHY_WIDTH, 6: physical register tag width.
- ROB_WIDTH, 5: ROB index width; ROB depth is 2^ROB_WIDTH.
- DATA_WIDTH, 32: immediate width.
- OP_WIDTH, 8: opaque decoded-op bundle width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  mispredict/exception squash
- rob_head  in  ROB_WIDTH  oldest in-flight ROB index
- dispatch_valid  in  1  dispatch request
- dispatch_ready  out  1  queue can accept
- dispatch_rob_id  in  ROB_WIDTH  ROB index of op
- dispatch_op  in  OP_WIDTH  decoded op bundle
- dispatch_prd  in  PHY_WIDTH  destination tag
- dispatch_prs1, dispatch_prs2  in  PHY_WIDTH  source tags
- dispatch_rs1_ready, dispatch_rs2_ready  in  1  source ready at rename
- dispatch_imm  in  DATA_WIDTH  immediate
- cdb_valid  in  1  wakeup broadcast valid
- cdb_prd  in  PHY_WIDTH  woken tag
- issue_valid  out  1  issue slot holds an op
- issue_ready  in  1  execution accepts slot
- issue_rob_id, issue_op, issue_prd, issue_prs1, issue_prs2, issue_imm  out  as dispatch  issued fields
- occupancy  out  $clog2(NUM_RS_ENTRIES)+1  valid entry count

Behaviour:
- Reset:
  - Priority: rst > flush > normal.
  - Reset clears all entry valid bits, issue_valid=0, all issue_* fields=0, occupancy=0.
  - dispatch_ready=0 while rst is high.
- dispatch_ready = !rst && (occupancy < NUM_RS_ENTRIES). It uses the registered count only, so it does not credit a same-cycle issue.
- Dispatch:
  - Accepted on a posedge with dispatch_valid && dispatch_ready.
  - Written into the lowest-index free entry.
  - Per-source ready bit = dispatch_rsN_ready OR (prsN==0) OR (cdb_valid && cdb_prd==prsN) in the same cycle.
- Wakeup: on each posedge with cdb_valid, every valid entry sets ready for each source whose tag equals cdb_prd. One broadcast per cycle.
- Select (combinational):
  - Eligible entry = valid and both sources ready, using registered bits. An entry woken this cycle is eligible next cycle.
  - Age = (rob_id - rob_head) mod 2^ROB_WIDTH; the smallest age wins.
  - Ties cannot occur (ROB ids are unique); the lower index wins defensively.
- Issue slot:
  - Loads when (!issue_valid || issue_ready) and an eligible entry exists.
  - On load, the selected entry is freed on the same edge and issue_valid=1.
  - If issue_ready && no eligible entry, issue_valid goes to 0.
  - Holding (issue_valid && !issue_ready): slot fields stable, no selection, entries retained.
- Latency:
  - Op dispatched with both sources ready at edge E: issue_valid=1 after edge E+1.
  - Op woken by CDB at edge W: issue_valid=1 after edge W+1 (slot free).
- Occupancy = previous + accept - issue_load, updated each edge. Simultaneous accept and load leaves it unchanged.
- flush:
  - Synchronous; clears all entries and the issue slot (issue_valid=0, occupancy=0).
  - A dispatch in the flush cycle is dropped; CDB is ignored that cycle.
- rob_id wrap-around is handled by the modular age; rob_head may advance any cycle.
- A dispatch whose slot would be the one freed this cycle is not possible, because free entries come from registered valid bits.

Test Plan:
- Reset, then dispatch rob 3, op 0x11, prs1=5, prs2=7 both ready, imm=0x10 at edge 1 -> issue_valid=1 after edge 2 with issue_rob_id=3, issue_imm=0x10; issue_ready=1 -> occupancy returns to 0.
- Dispatch rob 4, prs1=9 not ready; CDB prd=9 at edge 5 -> no issue before edge 6, issue_valid=1 after edge 6. A second case with cdb_prd=9 in the dispatch cycle -> issues one cycle after acceptance.
- Fill 8 entries with unready sources -> occupancy=8, dispatch_ready=0; further dispatch_valid is not accepted; wake one tag -> ready and issue, then dispatch_ready=1.
- rob_head=30; ready entries rob 31, 1, 30 -> issue order 30, 31, 1 (wrap age ordering).
- issue_ready=0 for 3 cycles with op in slot -> fields stable, issue_valid held, other ready entries not removed; release -> next oldest loads on the same edge.
- Mid-operation flush with 5 entries and a valid slot -> next cycle issue_valid=0, occupancy=0, dispatch_ready=1; rst asserted concurrently with flush gives the same result.
